// File: rtl/ripple_carry_adder.sv
`default_nettype none
// ============================================================================
//  Module      : ripple_carry_adder
//  Description : Registered unsigned adder built from a structural chain of
//                one-bit full adders. Computes {Cout,sum} = A + B + Cin and
//                captures the result one clock after in_valid is sampled.
//  Revision    : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      operand / sum width in bits (1..64), default 4
//  Ports
//    clk        rising-edge clock
//    rst        asynchronous reset, active-high
//    in_valid   qualifies A, B and Cin this cycle
//    A, B       unsigned operands [WIDTH-1:0]
//    Cin        carry into bit 0
//    sum        registered A+B+Cin modulo 2^WIDTH
//    Cout       registered carry out of the MSB
//    out_valid  one-cycle strobe marking a new result on sum/Cout
//    ovf        (only with RIPPLE_CARRY_ADDER_OVF_EN) registered
//               two's-complement overflow of A+B+Cin
//  Build option
//    RIPPLE_CARRY_ADDER_OVF_EN  adds the ovf output port
// ============================================================================

// ----------------------------------------------------------------------------
//  One-bit full adder cell used to build the carry chain.
// ----------------------------------------------------------------------------
module ripple_carry_adder_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic w_prop;

    // Propagate term is shared between the sum bit and the carry.
    assign w_prop = a_i ^ b_i;
    assign s_o    = w_prop ^ c_i;
    assign c_o    = (a_i & b_i) | (c_i & w_prop);

endmodule : ripple_carry_adder_fa

// ----------------------------------------------------------------------------
//  Top level: carry chain plus output register.
// ----------------------------------------------------------------------------
module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] sum,
    output logic             Cout,
    output logic             out_valid
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // ------------------------------------------------------------------
    // Combinational carry chain: w_carry[i] is the carry into bit i,
    // w_carry[WIDTH] is the carry out of the MSB.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    assign w_carry[0] = Cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_fa
            ripple_carry_adder_fa u_fa (
                .a_i (A[i]),
                .b_i (B[i]),
                .c_i (w_carry[i]),
                .s_o (w_sum[i]),
                .c_o (w_carry[i+1])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register. The chain result is only selected when in_valid
    // is high, so unknown operand values while idle never reach the
    // registers.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             valid_q, valid_d;

    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d  = w_sum;
            cout_d = w_carry[WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign Cout      = cout_q;
    assign out_valid = valid_q;

`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    // ------------------------------------------------------------------
    // Signed overflow: carry into the sign bit differs from carry out.
    // For WIDTH=1 the carry into the sign bit is Cin itself.
    // ------------------------------------------------------------------
    logic w_ovf;
    logic ovf_q, ovf_d;

    assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

    always_comb begin
        ovf_d = ovf_q;
        if (in_valid) begin
            ovf_d = w_ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule : ripple_carry_adder

`default_nettype wire

// File: tb/tb_ripple_carry_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ripple_carry_adder
//  Description : Self-checking bench for ripple_carry_adder (WIDTH=4).
//                Expected results come from integer arithmetic on the
//                operands; inputs change and outputs are sampled on the
//                falling clock edge.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_ripple_carry_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic [W-1:0] sum;
    logic         Cout;
    logic         out_valid;
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_checks;
    int n_fail;

    // Expected registered state as seen after the next rising edge
    logic [W:0]   exp_res;
    logic         exp_valid;
    logic         exp_ovf;

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .sum       (sum),
        .Cout      (Cout),
        .out_valid (out_valid)
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        int unsigned t;
        t = int'(a) + int'(b) + int'(cin);
        return (W+1)'(t);
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin);
        int sa, sb, s;
        sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
        s  = sa + sb + int'(cin);
        return (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        // in_valid held high throughout reset
        rst = 1'b1; in_valid = 1'b1; A = 4'd5; B = 4'd3; Cin = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, Cout, sum} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_hold_valid: got {ov,co,sum}=%b, want 000000", {out_valid, Cout, sum});
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_valid, Cout, sum} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_no_result: got {ov,co,sum}=%b, want 000000", {out_valid, Cout, sum});
        end
        // load a non-zero result, then assert reset mid-cycle
        in_valid = 1'b1; A = 4'd7; B = 4'd6; Cin = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, Cout, sum} !== {1'b1, ref_add(4'd7, 4'd6, 1'b1)}) begin
            n_fail++;
            $display("FAIL reset_preload: got {ov,co,sum}=%b, want %b", {out_valid, Cout, sum},
                     {1'b1, ref_add(4'd7, 4'd6, 1'b1)});
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, Cout, sum} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_async: got {ov,co,sum}=%b, want 000000", {out_valid, Cout, sum});
        end
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b, want 0", ovf);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        // in-flight result dropped by reset before its capturing edge
        in_valid = 1'b1; A = 4'd9; B = 4'd9; Cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        // that one was legit; now launch another and kill it
        in_valid = 1'b1; A = 4'd3; B = 4'd4; Cin = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        n_checks++;
        if ({out_valid, Cout, sum} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_inflight: got {ov,co,sum}=%b, want 000000", {out_valid, Cout, sum});
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, Cout, sum} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_after_drop: got {ov,co,sum}=%b, want 000000", {out_valid, Cout, sum});
        end
        exp_res = '0; exp_ovf = 1'b0; exp_valid = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5] = '{4'b0000, 4'b0101, 4'b1111, 4'b1010, 4'b1111};
        logic [W-1:0] tb [5] = '{4'b0000, 4'b0011, 4'b0001, 4'b0101, 4'b1111};
        logic         tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; A = ta[i]; B = tb[i]; Cin = tc[i];
            exp_res = ref_add(ta[i], tb[i], tc[i]);
            exp_ovf = ref_ovf(ta[i], tb[i], tc[i]);
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if ({out_valid, Cout, sum} !== {1'b1, exp_res}) begin
                n_fail++;
                $display("FAIL directed[%0d]: got {ov,co,sum}=%b, want %b", i,
                         {out_valid, Cout, sum}, {1'b1, exp_res});
            end
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
            n_checks++;
            if (ovf !== exp_ovf) begin
                n_fail++;
                $display("FAIL directed_ovf[%0d]: got %b, want %b", i, ovf, exp_ovf);
            end
`endif
            @(negedge clk);
            n_checks++;
            if ({out_valid, Cout, sum} !== {1'b0, exp_res}) begin
                n_fail++;
                $display("FAIL directed_idle[%0d]: got {ov,co,sum}=%b, want %b", i,
                         {out_valid, Cout, sum}, {1'b0, exp_res});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ta [3] = '{4'b1111, 4'b1010, 4'b1111};
        logic [W-1:0] tb [3] = '{4'b0001, 4'b0101, 4'b1111};
        logic         tc [3] = '{1'b0, 1'b1, 1'b1};
        logic [W:0]   pend;
        pend = '0;
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) begin
                n_checks++;
                if ({out_valid, Cout, sum} !== {1'b1, pend}) begin
                    n_fail++;
                    $display("FAIL back_to_back[%0d]: got {ov,co,sum}=%b, want %b", i - 1,
                             {out_valid, Cout, sum}, {1'b1, pend});
                end
            end
            if (i < 3) begin
                in_valid = 1'b1; A = ta[i]; B = tb[i]; Cin = tc[i];
                pend = ref_add(ta[i], tb[i], tc[i]);
                exp_ovf = ref_ovf(ta[i], tb[i], tc[i]);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        exp_res = pend;
        n_checks++;
        if ({out_valid, Cout, sum} !== {1'b0, exp_res}) begin
            n_fail++;
            $display("FAIL back_to_back_end: got {ov,co,sum}=%b, want %b",
                     {out_valid, Cout, sum}, {1'b0, exp_res});
        end
    endtask

    task automatic test_hold();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
            @(negedge clk);
            n_checks++;
            if ({out_valid, Cout, sum} !== {1'b0, exp_res}) begin
                n_fail++;
                $display("FAIL hold[%0d]: got {ov,co,sum}=%b, want %b", i,
                         {out_valid, Cout, sum}, {1'b0, exp_res});
            end
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
            n_checks++;
            if (ovf !== exp_ovf) begin
                n_fail++;
                $display("FAIL hold_ovf[%0d]: got %b, want %b", i, ovf, exp_ovf);
            end
`endif
        end
    endtask

    task automatic test_sweep();
        logic [W:0] pend;
        logic       pend_ovf;
        pend = '0; pend_ovf = 1'b0;
        for (int v = 0; v <= 512; v++) begin
            if (v > 0) begin
                n_checks++;
                if ({out_valid, Cout, sum} !== {1'b1, pend}) begin
                    n_fail++;
                    $display("FAIL sweep[%0d]: got {ov,co,sum}=%b, want %b", v - 1,
                             {out_valid, Cout, sum}, {1'b1, pend});
                end
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
                n_checks++;
                if (ovf !== pend_ovf) begin
                    n_fail++;
                    $display("FAIL sweep_ovf[%0d]: got %b, want %b", v - 1, ovf, pend_ovf);
                end
`endif
            end
            if (v < 512) begin
                in_valid = 1'b1;
                A   = W'(v >> 5);
                B   = W'(v >> 1);
                Cin = 1'(v);
                pend     = ref_add(A, B, Cin);
                pend_ovf = ref_ovf(A, B, Cin);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        exp_res = pend; exp_ovf = pend_ovf;
    endtask

    task automatic test_random();
        logic [W:0] pend;
        logic       pend_valid;
        logic       pend_ovf;
        pend = exp_res; pend_ovf = exp_ovf; pend_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'($urandom);
            A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
            if (in_valid) begin
                pend     = ref_add(A, B, Cin);
                pend_ovf = ref_ovf(A, B, Cin);
            end
            pend_valid = in_valid;
            @(negedge clk);
            n_checks++;
            if ({out_valid, Cout, sum} !== {pend_valid, pend}) begin
                n_fail++;
                $display("FAIL random[%0d]: got {ov,co,sum}=%b, want %b", i,
                         {out_valid, Cout, sum}, {pend_valid, pend});
            end
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
            n_checks++;
            if (ovf !== pend_ovf) begin
                n_fail++;
                $display("FAIL random_ovf[%0d]: got %b, want %b", i, ovf, pend_ovf);
            end
`endif
        end
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_res   = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold();
        test_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ripple_carry_adder

`default_nettype wire
